// File: rtl/apb_slv_pkg.sv
// Shared definitions for the APB wait-state completer: FSM encoding,
// wait counter width and the byte-address to word-index helper.
package apb_slv_pkg;

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    // Word index of a byte address; callers zero-extend paddr to 32 bits.
    function automatic logic [31:0] word_idx(input logic [31:0] paddr);
        return paddr >> 2;
    endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Loadable down-counter used to time the wait states of one APB transfer.
// Load has priority over decrement; decrementing stops at zero.
module apb_wait_cnt
    import apb_slv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load, saturating decrement, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer with a small word-addressed register file and a fixed
// number of wait states per transfer. Out-of-range indices answer with
// pslverr and read data 0; error writes are dropped.
// Optional byte strobes: define APB_WAIT_SLAVE_PSTRB_EN to add pstrb.
module apb_wait_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;

    apb_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    logic [STRB_W-1:0] strb_q, strb_d;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    logic [31:0]       word_full;
    logic              addr_err;
    logic [IDX_W-1:0]  idx_in;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val, cnt_val;

    assign word_full = word_idx(32'(paddr));
    assign addr_err  = (word_full >= 32'(DEPTH));
    assign idx_in    = word_full[IDX_W-1:0];

    apb_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    // FSM next state, transfer latches, counter control and response outputs.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        prdata_d     = prdata_q;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        strb_d       = strb_q;
`endif
        cnt_load     = 1'b0;
        cnt_load_val = CNT_W'(WAIT_CYC);
        cnt_dec      = 1'b0;
        mem_we       = 1'b0;
        pready       = 1'b0;
        pslverr      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A lone penable without a setup phase is ignored.
                if (psel && !penable) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d  = StAccess;
                write_d  = pwrite;
                idx_d    = idx_in;
                wdata_d  = pwdata;
                err_d    = addr_err;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
                strb_d   = pstrb;
`endif
                cnt_load = 1'b1;
                if (!pwrite) begin
                    prdata_d = addr_err ? '0 : mem_q[idx_in];
                end
            end
            StAccess: begin
                pready  = cnt_zero;
                pslverr = err_q & cnt_zero;
                if (cnt_zero) begin
                    mem_we  = write_q & ~err_q;
                    state_d = (psel && !penable) ? StSetup : StIdle;
                end else if (!psel) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_d      = StIdle;
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Write data merged with the current word for partial-strobe writes.
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    always_comb begin
        mem_wdata = mem_q[idx_q];
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) begin
                mem_wdata[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end
`else
    assign mem_wdata = wdata_q;
`endif

    // State and transfer latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
            strb_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
            strb_q   <= strb_d;
`endif
        end
    end

    // Register file, cleared on reset, written at transfer completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    assign prdata = prdata_q;

    // Reference of the count output keeps it observable for debug probes.
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Self-checking bench for apb_wait_slave: directed scenarios followed by
// randomized transfers, all compared against an array-based memory model.
module tb_apb_wait_slave;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned WAIT_CYC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    logic [3:0]        pstrb;
`endif
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    apb_wait_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        .pstrb   (pstrb),
`endif
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic go_idle(input int cycles);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // One complete transfer; returns in the completion cycle so a following
    // call runs back-to-back with no idle cycle.
    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int          n;
        int          idx;
        bit          err;
        logic [31:0] exp_rd;
        idx = int'(addr) >> 2;
        err = (idx >= DEPTH);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        pstrb   = strb;
`endif
        @(negedge clk);
        penable = 1'b1;
        check_eq("setup_pready", {31'd0, pready}, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!pready) begin
                // Bus changes during the access phase must be ignored.
                paddr  = ADDR_W'($urandom);
                pwdata = $urandom;
            end
        end while (!pready && n < 64);
        check_eq("wait_len", n, WAIT_CYC + 1);
        check_eq("pslverr", {31'd0, pslverr}, {31'd0, err});
        if (!wr) begin
            exp_rd = err ? 32'd0 : model_mem[idx];
            check_eq("prdata", prdata, exp_rd);
        end else if (!err) begin
`ifdef APB_WAIT_SLAVE_PSTRB_EN
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
`else
            model_mem[idx] = data;
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        pstrb = 4'hF;
`endif
        model_clear();
        repeat (2) @(negedge clk);
        check_eq("rst_pready", {31'd0, pready}, 32'd0);
        check_eq("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check_eq("rst_prdata", prdata, 32'd0);
        rst = 1'b0;
        go_idle(1);

        // Read after reset, then write/read back-to-back.
        apb_xfer(1'b0, 8'h0C, 32'h0, 4'hF);
        go_idle(1);
        apb_xfer(1'b1, 8'h14, 32'hDEADBEEF, 4'hF);
        apb_xfer(1'b0, 8'h14, 32'h0, 4'hF);
        check_eq("b2b_rd", prdata, 32'hDEADBEEF);
        go_idle(1);

        // Out-of-range write and reads.
        apb_xfer(1'b1, 8'h40, 32'h12345678, 4'hF);
        apb_xfer(1'b0, 8'h00, 32'h0, 4'hF);
        apb_xfer(1'b0, 8'h40, 32'h0, 4'hF);
        check_eq("err_rd_data", prdata, 32'd0);
        go_idle(1);

        // Abandoned write leaves the old value.
        apb_xfer(1'b1, 8'h08, 32'h0BADF00D, 4'hF);
        go_idle(1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hA5A5A5A5;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        pstrb = 4'hF;
`endif
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check_eq("abort_pready0", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check_eq("abort_pready1", {31'd0, pready}, 32'd0);
        go_idle(2);
        apb_xfer(1'b0, 8'h08, 32'h0, 4'hF);
        check_eq("abort_keep", prdata, 32'h0BADF00D);
        go_idle(1);

        // Reset in the middle of a write's wait states.
        apb_xfer(1'b0, 8'h14, 32'h0, 4'hF);
        go_idle(1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h77;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check_eq("rstmid_pready", {31'd0, pready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_eq("rstmid_prdata", prdata, 32'd0);
        check_eq("rstmid_pready2", {31'd0, pready}, 32'd0);
        check_eq("rstmid_pslverr", {31'd0, pslverr}, 32'd0);
        // penable without a setup phase.
        psel = 1'b1; penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("lone_penable", {31'd0, pready}, 32'd0);
        end
        go_idle(1);
        apb_xfer(1'b0, 8'h04, 32'h0, 4'hF);
        apb_xfer(1'b0, 8'h14, 32'h0, 4'hF);
        go_idle(1);

`ifdef APB_WAIT_SLAVE_PSTRB_EN
        apb_xfer(1'b1, 8'h10, 32'hFFFFFFFF, 4'hF);
        apb_xfer(1'b1, 8'h10, 32'h11223344, 4'b0101);
        apb_xfer(1'b1, 8'h10, 32'h99999999, 4'b0000);
        apb_xfer(1'b0, 8'h10, 32'h0, 4'hF);
        check_eq("strb_merge", prdata, 32'hFF22FF44);
        go_idle(1);
`endif

        // Randomized traffic with random gaps or back-to-back issue.
        for (int t = 0; t < 60; t++) begin
            bit          wr;
            logic [7:0]  addr;
            addr = 8'($urandom_range(0, 19)) << 2;
            wr   = 1'($urandom_range(0, 1));
            apb_xfer(wr, addr, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
        end
        go_idle(1);
        for (int i = 0; i < DEPTH; i++) apb_xfer(1'b0, 8'(i * 4), 32'h0, 4'hF);
        go_idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
